reboot_ctrl: RTL
================

Name: reboot_ctrl

Overview:
- Initiator side of the system reset path: requests resets rather than generating them.
- Accepts keyed reboot requests from the SoC control bus in the clk_1x domain.
- After a programmable hold-off, it either:
  - drives a timed reset-request pulse into the clock/reset manager's PLL reset input (full system reset), or
  - drives the SB_WARMBOOT boot/select pins (image reload).
- Optionally includes a watchdog that raises the same reset request autonomously.

Parameters:
- DELAY_CYCLES, 1024: hold-off cycles between request acceptance and pulse start; must be >= 1.
- PULSE_CYCLES, 16: width of the rst_req / wb_boot assertion in cycles; must be >= 1.
- KEY, 8'hA5: arming key; a request is valid only if req_key == KEY.
- WDT_CYCLES, 1048576: watchdog timeout in cycles (used only with REBOOT_WDT_EN).

Ports:
- clk  in  1  system clock (clk_1x domain)
- rst  in  1  reset; one clock, synchronous, active-high
- req_stb  in  1  single-cycle request strobe
- req_key  in  8  arming key sampled with req_stb
- req_boot  in  1  1 = warmboot request, 0 = plain system reset request
- req_sel  in  2  warmboot image select, sampled with req_stb
- kick  in  1  watchdog kick strobe
- busy  out  1  request accepted, sequence in progress or done
- err  out  1  one-cycle pulse: rejected request (bad key, or strobe while busy)
- rst_req  out  1  reset request to the clock/reset manager, active-high
- wb_boot  out  1  to SB_WARMBOOT BOOT
- wb_sel  out  2  to SB_WARMBOOT S1:S0
- wdt_fired  out  1  sticky: watchdog caused the current sequence

Behaviour:
- All outputs are registered. Reset values:
  - busy = 0, err = 0, rst_req = 0, wb_boot = 0, wb_sel = 2'b00, wdt_fired = 0.
  - FSM = IDLE, counters = 0.
- FSM states:
  - IDLE -> DELAY: on an accepted request.
  - DELAY -> PULSE: when the counter reaches 0.
  - PULSE -> HOLD: when the counter reaches 0.
  - HOLD: terminal; only rst exits it.
- Accept rule: req_stb = 1 and req_key == KEY in IDLE.
  - Latch req_boot to an internal mode bit; latch req_sel to wb_sel.
  - Load the counter with DELAY_CYCLES-1.
- Timing for a request accepted in cycle N:
  - busy = 1 from N+1 onward.
  - DELAY occupies cycles N+1 .. N+DELAY_CYCLES.
  - PULSE occupies cycles N+DELAY_CYCLES+1 .. N+DELAY_CYCLES+PULSE_CYCLES.
- During PULSE:
  - mode = 0: rst_req = 1, wb_boot = 0.
  - mode = 1: wb_boot = 1, rst_req = 0.
  - wb_sel is stable from N+1, i.e. at least DELAY_CYCLES cycles before wb_boot rises.
- HOLD: rst_req = 0, wb_boot = 0, busy = 1, wb_sel held. No further requests are accepted.
- err = 1 for exactly one cycle (the cycle after the strobe) when either:
  - req_stb with a wrong key in IDLE (state unchanged), or
  - req_stb with any key in DELAY, PULSE or HOLD (sequence unaffected; latched wb_sel/mode unchanged).
- Counter width: clog2 of max(DELAY_CYCLES, PULSE_CYCLES, WDT_CYCLES), minimum 1 bit. Decrement only; no wrap.
- rst asserted mid-sequence:
  - All outputs return to reset values on the next edge, including dropping rst_req/wb_boot mid-pulse.
  - The FSM returns to IDLE.

Optional Feature:
- Macro: REBOOT_WDT_EN.
- Defined:
  - Watchdog is disarmed after rst. The first kick arms it and loads wdt_cnt = WDT_CYCLES-1.
  - Each later kick reloads wdt_cnt. wdt_cnt decrements each cycle while armed and the FSM is in IDLE.
  - wdt_cnt == 0 while in IDLE is treated as an accepted plain-reset request (mode = 0, wb_sel unchanged), and sets wdt_fired = 1.
  - A valid req_stb in the same cycle as expiry wins (its req_boot/req_sel are used, wdt_fired stays 0).
  - The watchdog is frozen once the FSM leaves IDLE.
- Not defined:
  - kick is ignored and wdt_fired is tied to 0.
  - No watchdog counter is instantiated.

Test Plan:
- Plain reset, DELAY_CYCLES=4, PULSE_CYCLES=3: req_stb with key A5, req_boot=0 at cycle 10 -> busy=1 from cycle 11; rst_req=1 in cycles 15-17; HOLD from 18 with rst_req=0; wb_boot stays 0.
- Warmboot: key A5, req_boot=1, req_sel=2'b10 at cycle 10 -> wb_sel=2'b10 from cycle 11; wb_boot=1 in cycles 15-17; rst_req stays 0.
- Bad key 8'h5A -> err=1 for one cycle, busy stays 0. A second strobe during DELAY with req_sel=2'b01 -> err pulse; wb_sel remains 2'b10 and pulse timing is unchanged.
- rst asserted at the second PULSE cycle -> rst_req=0 and busy=0 on the next edge. A fresh valid request then replays the full timing.
- REBOOT_WDT_EN, WDT_CYCLES=8:
  - Kick at cycle 0, no further kicks -> expiry is accepted at cycle 8, rst_req pulses at 13-15, wdt_fired=1.
  - Kicking every 5 cycles -> no pulse, wdt_fired=0.
- REBOOT_WDT_EN: valid req_stb with req_boot=1 in the expiry cycle -> warmboot sequence runs, wdt_fired=0.

Source files
------------

// File: rtl/reboot_ctrl.sv
// reboot_ctrl: keyed reboot requester, drives rst_req or SB_WARMBOOT pins after a hold-off
// Define REBOOT_WDT_EN to add a watchdog that raises the same request on its own.
module reboot_ctrl #(
    parameter int         DELAY_CYCLES = 1024,
    parameter int         PULSE_CYCLES = 16,
    parameter logic [7:0] KEY          = 8'hA5,
    parameter int         WDT_CYCLES   = 1048576
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_stb,
    input  logic [7:0] req_key,
    input  logic       req_boot,
    input  logic [1:0] req_sel,
    input  logic       kick,
    output logic       busy,
    output logic       err,
    output logic       rst_req,
    output logic       wb_boot,
    output logic [1:0] wb_sel,
    output logic       wdt_fired
);
    localparam int DP   = DELAY_CYCLES > PULSE_CYCLES ? DELAY_CYCLES : PULSE_CYCLES;
    localparam int MAXC = DP > WDT_CYCLES ? DP : WDT_CYCLES;
    localparam int CW   = MAXC > 1 ? $clog2(MAXC) : 1;
    localparam logic [CW-1:0] DLY_LD = CW'(DELAY_CYCLES - 1);
    localparam logic [CW-1:0] PLS_LD = CW'(PULSE_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, DELAY, PULSE, HOLD} state_t;

    state_t        state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic          mode, mode_nx;
    logic [1:0]    sel_nx;
    logic          busy_nx, err_nx, rst_req_nx, wb_boot_nx, fired_nx;
    logic          req_ok, expire;

    assign req_ok = req_stb && req_key == KEY && state == IDLE;

`ifdef REBOOT_WDT_EN
    localparam logic [CW-1:0] WDT_LD = CW'(WDT_CYCLES - 1);
    logic          armed;
    logic [CW-1:0] wdt_cnt;
    assign expire = armed && wdt_cnt == '0 && state == IDLE;
    // Watchdog only runs in IDLE; it is frozen for the rest of the sequence.
    always_ff @(posedge clk) begin
        if (rst) begin
            armed   <= 1'b0;
            wdt_cnt <= '0;
        end else if (state == IDLE) begin
            if (kick) begin
                armed   <= 1'b1;
                wdt_cnt <= WDT_LD;
            end else if (armed && wdt_cnt != '0) begin
                wdt_cnt <= wdt_cnt - CW'(1);
            end
        end
    end
`else
    logic unused_kick;
    assign unused_kick = kick;
    assign expire      = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            mode      <= 1'b0;
            wb_sel    <= 2'b00;
            busy      <= 1'b0;
            err       <= 1'b0;
            rst_req   <= 1'b0;
            wb_boot   <= 1'b0;
            wdt_fired <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            mode      <= mode_nx;
            wb_sel    <= sel_nx;
            busy      <= busy_nx;
            err       <= err_nx;
            rst_req   <= rst_req_nx;
            wb_boot   <= wb_boot_nx;
            wdt_fired <= fired_nx;
        end
    end

    // A valid strobe beats a simultaneous watchdog expiry.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        mode_nx  = mode;
        sel_nx   = wb_sel;
        fired_nx = wdt_fired;
        case (state)
            IDLE: if (req_ok || expire) begin
                state_nx = DELAY;
                cnt_nx   = DLY_LD;
                mode_nx  = req_ok ? req_boot : 1'b0;
                sel_nx   = req_ok ? req_sel : wb_sel;
                fired_nx = !req_ok;
            end
            DELAY: begin
                state_nx = cnt == '0 ? PULSE : DELAY;
                cnt_nx   = cnt == '0 ? PLS_LD : cnt - CW'(1);
            end
            PULSE: begin
                state_nx = cnt == '0 ? HOLD : PULSE;
                cnt_nx   = cnt == '0 ? cnt : cnt - CW'(1);
            end
            HOLD: ;
            default: state_nx = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so the registers line up with it.
    always_comb begin
        busy_nx    = state_nx != IDLE;
        rst_req_nx = state_nx == PULSE && !mode_nx;
        wb_boot_nx = state_nx == PULSE && mode_nx;
        err_nx     = req_stb && !req_ok;
    end
endmodule
